// File: rtl/jtag_cmd_pkg.sv
// jtag_cmd_pkg: shared types and field positions for the JTAG command bridge.
// Optional feature macro used by the bridge: JTAG_CMD_TIMEOUT_EN.
package jtag_cmd_pkg;

   // command opcodes carried in word[31:28]
   typedef enum logic [3:0] {
      OP_NOP      = 4'h0,
      OP_SET_ADDR = 4'h1,
      OP_WRITE    = 4'h2,
      OP_READ     = 4'h3,
      OP_STATUS   = 4'h4
   } op_e;

   // bridge FSM: either idle or holding a bus request
   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_REQ  = 1'b1
   } state_e;

   // command word fields
   localparam int OP_HI    = 31;
   localparam int OP_LO    = 28;
   localparam int PAY_HI   = 23;
   localparam int PAY_LO   = 0;
   localparam int PAY_W    = PAY_HI - PAY_LO + 1;
   localparam int AINC_BIT = 23;

   // response word bit positions
   localparam int RSP_BUSY = 31;
   localparam int RSP_ERR  = 30;
   localparam int RSP_OVR  = 29;
   localparam int RSP_TMO  = 28;

   // assemble a response word from status flags and zero-extended read data
   function automatic logic [31:0] build_rsp(input logic busy, input logic err,
                                             input logic ovr, input logic tmo,
                                             input logic [PAY_W-1:0] rd);
      logic [31:0] r;
      r           = '0;
      r[RSP_BUSY] = busy;
      r[RSP_ERR]  = err;
      r[RSP_OVR]  = ovr;
      r[RSP_TMO]  = tmo;
      r[PAY_W-1:0] = rd;
      return r;
   endfunction

endpackage

// File: rtl/jtag_cmd_bridge_timer.sv
// jtag_cmd_timer: bus-request watchdog for the JTAG command bridge.
// Instantiated by jtag_cmd_bridge only when JTAG_CMD_TIMEOUT_EN is defined.
// Loads TIMEOUT on start and counts down; expired is high during the cycle
// whose closing edge is the TIMEOUT-th edge after start.
module jtag_cmd_timer #(
   parameter int TIMEOUT = 255
) (
   input  logic tck,
   input  logic trst,
   input  logic start,
   input  logic clear,
   output logic expired
);

   logic [7:0] cnt;

   // down-counter: clear wins, start reloads, otherwise count toward zero
   always_ff @(posedge tck or negedge trst) begin
      if (!trst)
         cnt <= '0;
      else if (clear)
         cnt <= '0;
      else if (start)
         cnt <= 8'(TIMEOUT);
      else if (cnt != 8'd0)
         cnt <= cnt - 8'd1;
   end

   assign expired = (cnt == 8'd1);

endmodule

// File: rtl/jtag_cmd_bridge.sv
// jtag_cmd_bridge: decodes 32-bit TAP user-register commands into single
// req/ack bus transactions and returns a 32-bit status/read-data response.
// Optional feature macro: JTAG_CMD_TIMEOUT_EN (bus request watchdog).
module jtag_cmd_bridge
   import jtag_cmd_pkg::*;
#(
   parameter int          ADDR_W    = 12,
   parameter int          DATA_W    = 16,
   parameter int          TIMEOUT   = 255,
   parameter logic [31:0] IDLE_WORD = 32'hE671_2945
) (
   input  logic              tck,
   input  logic              trst,
   input  logic [31:0]       user_data_i,
   input  logic              user_valid_i,
   output logic [31:0]       user_data_o,
   output logic              bus_req_o,
   output logic              bus_we_o,
   output logic [ADDR_W-1:0] bus_addr_o,
   output logic [DATA_W-1:0] bus_wdata_o,
   input  logic              bus_ack_i,
   input  logic [DATA_W-1:0] bus_rdata_i
);

   state_e            state, state_nx;
   logic [ADDR_W-1:0] addr, addr_nx;
   logic              ainc, ainc_nx;
   logic              err, err_nx;
   logic              ovr, ovr_nx;
   logic              tmo, tmo_nx;
   logic [DATA_W-1:0] rdata, rdata_nx;
   logic [31:0]       rsp, rsp_nx;
   logic              rsp_load;
   logic              accept, done, abort, drop;
   logic              expired;
   logic [3:0]        cmd_op;
   logic [PAY_W-1:0]  payload;
   logic [PAY_W-1:0]  rd_ext;
   logic              bus_we;
   logic [ADDR_W-1:0] bus_addr;
   logic [DATA_W-1:0] bus_wdata;

   assign cmd_op  = user_data_i[OP_HI:OP_LO];
   assign payload = user_data_i[PAY_HI:PAY_LO];

`ifdef JTAG_CMD_TIMEOUT_EN
   logic unused_bits;
   assign unused_bits = ^user_data_i;

   jtag_cmd_timer #(
      .TIMEOUT(TIMEOUT)
   ) u_timer (
      .tck    (tck),
      .trst   (trst),
      .start  (accept),
      .clear  (done | abort),
      .expired(expired)
   );
`else
   // no watchdog: a request waits for its ack indefinitely
   logic unused_bits;
   assign unused_bits = ^{user_data_i, TIMEOUT[0]};
   assign expired     = 1'b0;
`endif

   // FSM state register
   always_ff @(posedge tck or negedge trst) begin
      if (!trst)
         state <= ST_IDLE;
      else
         state <= state_nx;
   end

   // FSM next state and transaction events
   always_comb begin
      state_nx = state;
      accept   = 1'b0;
      done     = 1'b0;
      abort    = 1'b0;
      drop     = 1'b0;
      case (state)
         ST_IDLE: begin
            if (user_valid_i && (cmd_op == OP_WRITE || cmd_op == OP_READ)) begin
               accept   = 1'b1;
               state_nx = ST_REQ;
            end
         end
         ST_REQ: begin
            // ack beats a same-cycle expiry
            if (bus_ack_i) begin
               done     = 1'b1;
               state_nx = ST_IDLE;
            end else if (expired) begin
               abort    = 1'b1;
               state_nx = ST_IDLE;
            end
            // any command arriving while busy is lost
            drop = user_valid_i;
         end
         default: state_nx = ST_IDLE;
      endcase
   end

   // command decode, flag updates and response assembly
   always_comb begin
      addr_nx  = addr;
      ainc_nx  = ainc;
      err_nx   = err;
      ovr_nx   = ovr;
      tmo_nx   = tmo;
      rdata_nx = rdata;
      rsp_load = 1'b0;
      rd_ext   = '0;
      rsp_nx   = rsp;

      if (state == ST_IDLE && user_valid_i) begin
         case (cmd_op)
            OP_NOP, OP_WRITE, OP_READ, OP_STATUS: ;
            OP_SET_ADDR: begin
               addr_nx = payload[ADDR_W-1:0];
               ainc_nx = payload[AINC_BIT];
            end
            default: err_nx = 1'b1;
         endcase
      end

      if (done) begin
         if (!bus_we)
            rdata_nx = bus_rdata_i;
         if (ainc)
            addr_nx = addr + ADDR_W'(1);
      end
      if (abort) begin
         err_nx = 1'b1;
         tmo_nx = 1'b1;
      end
      if (drop)
         ovr_nx = 1'b1;

      rd_ext[DATA_W-1:0] = rdata_nx;
      rsp_nx   = build_rsp(state_nx == ST_REQ, err_nx, ovr_nx, tmo_nx, rd_ext);
      rsp_load = user_valid_i | done | abort;

      // STATUS reports the flags as they were, then clears them
      if (state == ST_IDLE && user_valid_i && cmd_op == OP_STATUS) begin
         err_nx = 1'b0;
         ovr_nx = 1'b0;
      end
   end

   // datapath registers: address, flags, read data, response, bus command
   always_ff @(posedge tck or negedge trst) begin
      if (!trst) begin
         addr      <= '0;
         ainc      <= 1'b0;
         err       <= 1'b0;
         ovr       <= 1'b0;
         tmo       <= 1'b0;
         rdata     <= '0;
         rsp       <= IDLE_WORD;
         bus_we    <= 1'b0;
         bus_addr  <= '0;
         bus_wdata <= '0;
      end else begin
         addr  <= addr_nx;
         ainc  <= ainc_nx;
         err   <= err_nx;
         ovr   <= ovr_nx;
         tmo   <= tmo_nx;
         rdata <= rdata_nx;
         if (rsp_load)
            rsp <= rsp_nx;
         if (accept) begin
            bus_we    <= (cmd_op == OP_WRITE);
            bus_addr  <= addr;
            bus_wdata <= payload[DATA_W-1:0];
         end
      end
   end

   // request follows the FSM state so reset removes it without a clock
   assign bus_req_o   = (state == ST_REQ);
   assign bus_we_o    = bus_we;
   assign bus_addr_o  = bus_addr;
   assign bus_wdata_o = bus_wdata;
   assign user_data_o = rsp;

endmodule

// File: tb/tb_jtag_cmd_bridge.sv
// tb_jtag_cmd_bridge: directed self-checking bench for jtag_cmd_bridge.
// Covers the watchdog path when JTAG_CMD_TIMEOUT_EN is defined.
module tb_jtag_cmd_bridge;

   logic        tck = 1'b0;
   logic        trst;
   logic [31:0] user_data_i;
   logic        user_valid_i;
   logic [31:0] user_data_o;
   logic        bus_req_o;
   logic        bus_we_o;
   logic [11:0] bus_addr_o;
   logic [15:0] bus_wdata_o;
   logic        bus_ack_i;
   logic [15:0] bus_rdata_i;

   int ntests = 0;
   int nfail  = 0;

   jtag_cmd_bridge #(
      .ADDR_W   (12),
      .DATA_W   (16),
      .TIMEOUT  (8),
      .IDLE_WORD(32'hE671_2945)
   ) dut (
      .tck         (tck),
      .trst        (trst),
      .user_data_i (user_data_i),
      .user_valid_i(user_valid_i),
      .user_data_o (user_data_o),
      .bus_req_o   (bus_req_o),
      .bus_we_o    (bus_we_o),
      .bus_addr_o  (bus_addr_o),
      .bus_wdata_o (bus_wdata_o),
      .bus_ack_i   (bus_ack_i),
      .bus_rdata_i (bus_rdata_i)
   );

   always #5 tck = ~tck;

   // advance one edge and settle
   task automatic tick();
      @(posedge tck);
      #1;
   endtask

   // strobe one command word for a single edge
   task automatic send(input logic [31:0] cmd);
      user_data_i  = cmd;
      user_valid_i = 1'b1;
      tick();
      user_valid_i = 1'b0;
   endtask

   // pulse ack for a single edge with given read data
   task automatic ack(input logic [15:0] rd);
      bus_rdata_i = rd;
      bus_ack_i   = 1'b1;
      tick();
      bus_ack_i   = 1'b0;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      ntests++;
      assert (obs === exp) else begin
         nfail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   initial begin
      trst         = 1'b0;
      user_data_i  = '0;
      user_valid_i = 1'b0;
      bus_ack_i    = 1'b0;
      bus_rdata_i  = '0;
      tick();
      tick();
      chk("rst_rsp",  user_data_o, 32'hE671_2945);
      chk("rst_req",  32'(bus_req_o), 32'd0);
      chk("rst_addr", 32'(bus_addr_o), 32'd0);
      chk("rst_we",   32'(bus_we_o), 32'd0);
      #3 trst = 1'b1;
      tick();

      // SET_ADDR 0x123 then WRITE 0xBEEF, ack on the third REQ edge
      send(32'h1000_0123);
      chk("setaddr_rsp", user_data_o, 32'h0000_0000);
      chk("setaddr_req", 32'(bus_req_o), 32'd0);
      send(32'h2000_BEEF);
      chk("wr_req",   32'(bus_req_o), 32'd1);
      chk("wr_addr",  32'(bus_addr_o), 32'h123);
      chk("wr_wdata", 32'(bus_wdata_o), 32'hBEEF);
      chk("wr_we",    32'(bus_we_o), 32'd1);
      chk("wr_busy",  user_data_o, 32'h8000_0000);
      tick();
      tick();
      chk("wr_hold", 32'(bus_req_o), 32'd1);
      ack(16'h0000);
      chk("wr_done_req", 32'(bus_req_o), 32'd0);
      chk("wr_done_rsp", user_data_o, 32'h0000_0000);

      // auto-increment reads
      send(32'h1080_0010);
      send(32'h3000_0000);
      chk("rd1_addr", 32'(bus_addr_o), 32'h010);
      chk("rd1_we",   32'(bus_we_o), 32'd0);
      ack(16'h1111);
      chk("rd1_req", 32'(bus_req_o), 32'd0);
      chk("rd1_rsp", user_data_o, 32'h0000_1111);
      send(32'h3000_0000);
      chk("rd2_addr", 32'(bus_addr_o), 32'h011);
      ack(16'h2222);
      chk("rd2_rsp", user_data_o, 32'h0000_2222);

      // overrun: second WRITE while busy is dropped
      send(32'h2000_AAAA);
      chk("ovr_addr", 32'(bus_addr_o), 32'h012);
      send(32'h2000_5555);
      chk("ovr_req",   32'(bus_req_o), 32'd1);
      chk("ovr_wdata", 32'(bus_wdata_o), 32'hAAAA);
      chk("ovr_rsp",   user_data_o, 32'hA000_2222);
      ack(16'h0000);
      chk("ovr_done", user_data_o, 32'h2000_2222);
      tick();
      chk("ovr_single", 32'(bus_req_o), 32'd0);
      send(32'h4000_0000);
      chk("stat1", user_data_o, 32'h2000_2222);
      send(32'h4000_0000);
      chk("stat2", user_data_o, 32'h0000_2222);

      // ack with no request is ignored
      ack(16'h3333);
      chk("stray_req", 32'(bus_req_o), 32'd0);
      chk("stray_rsp", user_data_o, 32'h0000_2222);

`ifdef JTAG_CMD_TIMEOUT_EN
      // ack on the expiry edge wins
      send(32'h3000_0000);
      chk("race_addr", 32'(bus_addr_o), 32'h013);
      repeat (7) tick();
      chk("race_hold", 32'(bus_req_o), 32'd1);
      ack(16'h4444);
      chk("race_req", 32'(bus_req_o), 32'd0);
      chk("race_rsp", user_data_o, 32'h0000_4444);
      // read with no ack times out after 8 edges
      send(32'h3000_0000);
      chk("tmo_addr", 32'(bus_addr_o), 32'h014);
      repeat (7) tick();
      chk("tmo_hold", 32'(bus_req_o), 32'd1);
      tick();
      chk("tmo_req", 32'(bus_req_o), 32'd0);
      chk("tmo_rsp", user_data_o, 32'h5000_4444);
      send(32'h4000_0000);
      chk("tmo_stat1", user_data_o, 32'h5000_4444);
      send(32'h4000_0000);
      chk("tmo_stat2", user_data_o, 32'h1000_4444);
      send(32'h3000_0000);
      chk("pend_addr", 32'(bus_addr_o), 32'h014);
`else
      // without the watchdog the request waits
      send(32'h3000_0000);
      chk("pend_addr", 32'(bus_addr_o), 32'h013);
      repeat (20) tick();
      chk("pend_req", 32'(bus_req_o), 32'd1);
      chk("pend_rsp", user_data_o, 32'h8000_2222);
`endif

      // asynchronous reset while the request is pending
      #3 trst = 1'b0;
      #1;
      chk("trst_req", 32'(bus_req_o), 32'd0);
      chk("trst_rsp", user_data_o, 32'hE671_2945);
      #1 trst = 1'b1;
      tick();
      chk("trst_idle", 32'(bus_req_o), 32'd0);

      // illegal op sets err
      send(32'h7000_0000);
      chk("ill_rsp", user_data_o, 32'h4000_0000);
      chk("ill_req", 32'(bus_req_o), 32'd0);
      send(32'h3000_0000);
      chk("post_addr", 32'(bus_addr_o), 32'h000);
      chk("post_busy", user_data_o, 32'hC000_0000);
      ack(16'h00AB);
      chk("post_rsp", user_data_o, 32'h4000_00AB);
      send(32'h3000_0000);
      chk("noinc_addr", 32'(bus_addr_o), 32'h000);
      ack(16'h00CD);
      send(32'h4000_0000);
      chk("ill_stat1", user_data_o, 32'h4000_00CD);
      send(32'h4000_0000);
      chk("ill_stat2", user_data_o, 32'h0000_00CD);

      $display("[TB] %0d tests run, %0d failed", ntests, nfail);
      $finish;
   end

endmodule
